// File: rtl/cheshire_cfg_seq_pkg.sv
// Shared types and helpers for the Cheshire post-reset configuration sequencer.
package cheshire_cfg_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        FAIL
    } state_e;

    function automatic int cfg_seq_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cheshire_cfg_seq.sv
// Walks a table of register writes over a single-outstanding request channel,
// retrying each entry on error or timeout and reporting done or the failing index.
module cheshire_cfg_seq
    import cheshire_cfg_seq_pkg::*;
#(
    parameter int NumEntries    = 8,
    parameter int AddrWidth     = 48,
    parameter int DataWidth     = 64,
    parameter int MaxRetries    = 3,
    parameter int TimeoutCycles = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic [NumEntries-1:0][AddrWidth-1:0] tbl_addr_i,
    input  logic [NumEntries-1:0][DataWidth-1:0] tbl_data_i,
    output logic                                 req_valid_o,
    input  logic                                 req_ready_i,
    output logic [AddrWidth-1:0]                 req_addr_o,
    output logic [DataWidth-1:0]                 req_wdata_o,
    input  logic                                 rsp_valid_i,
    input  logic                                 rsp_error_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 error_o,
    output logic [cfg_seq_idx_width(NumEntries)-1:0] err_idx_o
);

    localparam int IdxW   = cfg_seq_idx_width(NumEntries);
    localparam int RetryW = cfg_seq_idx_width(MaxRetries + 1);
    localparam int TmoW   = cfg_seq_idx_width(TimeoutCycles + 1);

    localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NumEntries - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MaxRetries);
    localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TimeoutCycles - 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [IdxW-1:0]   err_idx_q, err_idx_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            tmo_q     <= '0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            err_idx_q <= err_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        err_idx_d = err_idx_q;
        unique case (state_q)
            IDLE, DONE, FAIL: begin
                if (start_i) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            ISSUE: begin
                if (req_ready_i) begin
                    state_d = WAIT;
                    tmo_d   = '0;
                end
            end
            WAIT: begin
                // A response in the expiry cycle wins over the timeout.
                if (rsp_valid_i && !rsp_error_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        idx_d   = idx_q + IdxW'(1);
                        retry_d = '0;
                    end
                end else if (rsp_valid_i || (tmo_q == TmoLast)) begin
                    if (retry_q < RetryMax) begin
                        state_d = ISSUE;
                        retry_d = retry_q + RetryW'(1);
                    end else begin
                        state_d   = FAIL;
                        err_idx_d = idx_q;
                    end
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_valid_o = (state_q == ISSUE);
    assign busy_o      = (state_q == ISSUE) || (state_q == WAIT);
    assign done_o      = (state_q == DONE);
    assign error_o     = (state_q == FAIL);
    assign err_idx_o   = err_idx_q;

    assign req_addr_o  = req_valid_o ? tbl_addr_i[idx_q] : '0;
    assign req_wdata_o = req_valid_o ? tbl_data_i[idx_q] : '0;

endmodule

// File: tb/tb_cheshire_cfg_seq.sv
// Directed self-checking bench for cheshire_cfg_seq: ideal path, backpressure,
// retry, exhaustion, timeout, reset and restart.
module tb_cheshire_cfg_seq;

    localparam int N  = 4;
    localparam int AW = 48;
    localparam int DW = 64;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [N-1:0][AW-1:0]  tbl_addr;
    logic [N-1:0][DW-1:0]  tbl_data;
    logic                  req_valid;
    logic                  req_ready = 1'b1;
    logic [AW-1:0]         req_addr;
    logic [DW-1:0]         req_wdata;
    logic                  rsp_valid = 1'b0;
    logic                  rsp_error = 1'b0;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [1:0]            err_idx;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [AW-1:0] hs_addr[$];
    logic [DW-1:0] hs_data[$];

    cheshire_cfg_seq #(
        .NumEntries   (N),
        .AddrWidth    (AW),
        .DataWidth    (DW),
        .MaxRetries   (3),
        .TimeoutCycles(16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .tbl_addr_i (tbl_addr),
        .tbl_data_i (tbl_data),
        .req_valid_o(req_valid),
        .req_ready_i(req_ready),
        .req_addr_o (req_addr),
        .req_wdata_o(req_wdata),
        .rsp_valid_i(rsp_valid),
        .rsp_error_i(rsp_error),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error),
        .err_idx_o  (err_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) begin
            hs_addr.push_back(req_addr);
            hs_data.push_back(req_wdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hs_count(input logic [AW-1:0] a);
        int c = 0;
        foreach (hs_addr[i]) if (hs_addr[i] === a) c++;
        return c;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for a request, optionally stalls it, then answers in the first WAIT cycle.
    task automatic serve(input int stall, input bit err, input string tag);
        int n;
        bit stable;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        n = 0;
        while (!req_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 64'(req_valid), 64'd1);
        if (stall > 0) begin
            req_ready = 1'b0;
            a0 = req_addr;
            d0 = req_wdata;
            stable = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (!(req_valid && req_addr === a0 && req_wdata === d0))
                    stable = 1'b0;
            end
            check({tag, "_stable"}, 64'(stable), 64'd1);
            req_ready = 1'b1;
        end
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_error = err;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
    endtask

    initial begin
        int c0;
        int n;
        tbl_addr[0] = 48'h0300_0000_0010;
        tbl_addr[1] = 48'h0300_0000_0020;
        tbl_addr[2] = 48'h0400_0000_0100;
        tbl_addr[3] = 48'h0500_0000_0008;
        tbl_data[0] = 64'h1111_0000_0000_0001;
        tbl_data[1] = 64'h2222_0000_0000_0002;
        tbl_data[2] = 64'h3333_0000_0000_0003;
        tbl_data[3] = 64'h4444_0000_0000_0004;

        repeat (3) @(negedge clk);
        check("rst_valid", 64'(req_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_addr", 64'(req_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // ideal path
        hs_addr.delete();
        hs_data.delete();
        c0 = cyc;
        pulse_start();
        check("ideal_busy", 64'(busy), 64'd1);
        for (int i = 0; i < N; i++) serve(0, 1'b0, "ideal");
        check("ideal_done", 64'(done), 64'd1);
        check("ideal_latency", 64'(cyc - c0), 64'd9);
        check("ideal_error", 64'(error), 64'd0);
        check("ideal_hs_n", 64'(hs_addr.size()), 64'd4);
        for (int i = 0; i < N; i++) check("ideal_hs_addr", 64'(hs_addr[i]), 64'(tbl_addr[i]));
        check("ideal_hs_data", hs_data[3], tbl_data[3]);

        // restart from DONE with backpressure on entry 1 and two errors on entry 2
        hs_addr.delete();
        hs_data.delete();
        pulse_start();
        check("rerun_done_clr", 64'(done), 64'd0);
        check("rerun_addr0", 64'(req_addr), 64'(tbl_addr[0]));
        serve(0, 1'b0, "rerun_e0");
        check("bp_addr1", 64'(req_addr), 64'(tbl_addr[1]));
        serve(5, 1'b0, "bp_e1");
        serve(0, 1'b1, "retry_e2a");
        serve(0, 1'b1, "retry_e2b");
        serve(0, 1'b0, "retry_e2c");
        serve(0, 1'b0, "rerun_e3");
        check("bp_hs_e1", 64'(hs_count(tbl_addr[1])), 64'd1);
        check("retry_hs_e2", 64'(hs_count(tbl_addr[2])), 64'd3);
        check("retry_done", 64'(done), 64'd1);
        check("retry_error", 64'(error), 64'd0);

        // retry exhaustion on entry 1
        hs_addr.delete();
        hs_data.delete();
        pulse_start();
        serve(0, 1'b0, "exh_e0");
        for (int i = 0; i < 4; i++) serve(0, 1'b1, "exh_e1");
        check("exh_error", 64'(error), 64'd1);
        check("exh_err_idx", 64'(err_idx), 64'd1);
        check("exh_done", 64'(done), 64'd0);
        check("exh_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        check("exh_hs_e1", 64'(hs_count(tbl_addr[1])), 64'd4);
        check("exh_hs_e2", 64'(hs_count(tbl_addr[2])), 64'd0);
        check("exh_valid", 64'(req_valid), 64'd0);

        // timeout on entry 0, then a response coincident with expiry
        hs_addr.delete();
        hs_data.delete();
        pulse_start();
        check("tmo_err_clr", 64'(error), 64'd0);
        check("tmo_req0", 64'(req_valid), 64'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_valid && n < 40);
        check("tmo_reissue_gap", 64'(n), 64'd17);
        check("tmo_reissue_addr", 64'(req_addr), 64'(tbl_addr[0]));
        repeat (16) @(negedge clk);
        check("tmo_wait_busy", 64'(busy), 64'd1);
        rsp_valid = 1'b1;
        rsp_error = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("tmo_coincident_addr", 64'(req_addr), 64'(tbl_addr[1]));
        for (int i = 1; i < N; i++) serve(0, 1'b0, "tmo_rest");
        check("tmo_done", 64'(done), 64'd1);
        check("tmo_hs_e0", 64'(hs_count(tbl_addr[0])), 64'd2);

        // reset asserted in WAIT, then a stray response
        hs_addr.delete();
        hs_data.delete();
        pulse_start();
        @(negedge clk);
        check("rstw_in_wait", 64'({busy, req_valid}), 64'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_busy", 64'(busy), 64'd0);
        check("rstw_done", 64'(done), 64'd0);
        check("rstw_err_idx", 64'(err_idx), 64'd0);
        check("rstw_wdata", 64'(req_wdata), 64'd0);
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        @(negedge clk);
        check("stray_state", 64'({busy, req_valid, done, error}), 64'd0);
        check("stray_hs", 64'(hs_addr.size()), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
